// File: rtl/mem_stream_beat_pump.sv
// mem_stream_beat_pump: converts multi-beat memory command streams into one
// FSM beat per bus word, and converts FSM response beats back into a
// response stream, replicating narrow read data across the bus word.
//
// Ports:
//   clk_i, reset_i                    clock, asynchronous active-high reset
//   in_*                              command stream (header/addr/size/wr/data, v/last, ready)
//   fsm_*                             per-word FSM beats (held header fields, wrapped addr, data, v/new/last, yumi)
//   rsp_*                             FSM response beats (header/size/wr/data, v, ready)
//   out_*                             response stream (header/data, v/last, ready)
module mem_stream_beat_pump #(
    parameter int unsigned paddr_width_p  = 40,
    parameter int unsigned data_width_p   = 64,
    parameter int unsigned block_width_p  = 512,
    parameter int unsigned header_width_p = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic [header_width_p-1:0] in_header_i,
    input  logic [paddr_width_p-1:0]  in_addr_i,
    input  logic [2:0]                in_size_i,
    input  logic                      in_wr_i,
    input  logic [data_width_p-1:0]   in_data_i,
    input  logic                      in_v_i,
    input  logic                      in_last_i,
    output logic                      in_ready_and_o,

    output logic [header_width_p-1:0] fsm_header_o,
    output logic [paddr_width_p-1:0]  fsm_addr_o,
    output logic [2:0]                fsm_size_o,
    output logic                      fsm_wr_o,
    output logic [data_width_p-1:0]   fsm_data_o,
    output logic                      fsm_v_o,
    output logic                      fsm_new_o,
    output logic                      fsm_last_o,
    input  logic                      fsm_yumi_i,

    input  logic [header_width_p-1:0] rsp_header_i,
    input  logic [2:0]                rsp_size_i,
    input  logic                      rsp_wr_i,
    input  logic [data_width_p-1:0]   rsp_data_i,
    input  logic                      rsp_v_i,
    output logic                      rsp_ready_and_o,

    output logic [header_width_p-1:0] out_header_o,
    output logic [data_width_p-1:0]   out_data_o,
    output logic                      out_v_o,
    output logic                      out_last_o,
    input  logic                      out_ready_and_i
);

    localparam int unsigned bus_bytes_lp      = data_width_p / 8;
    localparam int unsigned lg_bus_bytes_lp   = $clog2(bus_bytes_lp);
    localparam int unsigned max_beats_lp      = block_width_p / data_width_p;
    localparam int unsigned lg_max_beats_lp   = $clog2(max_beats_lp);
    localparam int unsigned lg_block_bytes_lp = $clog2(block_width_p / 8);
    localparam int unsigned cnt_w_lp          = (lg_max_beats_lp == 0) ? 1 : lg_max_beats_lp;
    localparam bit          legal_width_lp    = (data_width_p == 8) || (data_width_p == 16)
                                             || (data_width_p == 32) || (data_width_p == 64);

    // Index of the final beat (beats-1) for a given log2 message size.
    function automatic logic [cnt_w_lp-1:0] last_idx(input logic [2:0] size);
        int unsigned sh;
        logic [cnt_w_lp-1:0] r;
        r  = '0;
        sh = 0;
        if (32'(size) > lg_bus_bytes_lp) begin
            sh = 32'(size) - lg_bus_bytes_lp;
            if (sh >= lg_max_beats_lp) r = cnt_w_lp'(max_beats_lp - 1);
            else                       r = cnt_w_lp'((32'd1 << sh) - 32'd1);
        end
        return r;
    endfunction

    // ---------------- forward path ----------------
    logic [cnt_w_lp-1:0]       fcnt;
    logic [header_width_p-1:0] hdr_r;
    logic [paddr_width_p-1:0]  addr_r;
    logic [2:0]                size_r;
    logic                      wr_r;

    logic                      first;
    logic [paddr_width_p-1:0]  addr_sel;
    logic [cnt_w_lp-1:0]       f_last_idx;
    logic [paddr_width_p-1:0]  word_base;
    logic [paddr_width_p-1:0]  word_mask;
    logic [paddr_width_p-1:0]  word_off;

    // First beat passes the command through; later beats use the held copy.
    always_comb begin
        first        = (fcnt == '0);
        fsm_header_o = first ? in_header_i : hdr_r;
        addr_sel     = first ? in_addr_i   : addr_r;
        fsm_size_o   = first ? in_size_i   : size_r;
        fsm_wr_o     = first ? in_wr_i     : wr_r;
        f_last_idx   = last_idx(fsm_size_o);
        fsm_new_o    = first;
        fsm_last_o   = (fcnt == f_last_idx);
        fsm_v_o      = in_v_i;
        fsm_data_o   = fsm_wr_o ? in_data_i : '0;
        // Reads hold their single command beat until the last FSM beat.
        in_ready_and_o = fsm_yumi_i & (fsm_wr_o | fsm_last_o);
    end

    // Wrapped burst: only the low log2(beats) bits of the word index advance.
    always_comb begin
        word_base  = addr_sel >> lg_bus_bytes_lp;
        word_mask  = paddr_width_p'(f_last_idx);
        word_off   = (word_base + paddr_width_p'(fcnt)) & word_mask;
        fsm_addr_o = ((word_base & ~word_mask) | word_off) << lg_bus_bytes_lp;
    end

    // Beat counter and held command fields.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fcnt   <= '0;
            hdr_r  <= '0;
            addr_r <= '0;
            size_r <= '0;
            wr_r   <= 1'b0;
        end else if (fsm_yumi_i) begin
            fcnt <= fsm_last_o ? '0 : fcnt + cnt_w_lp'(1);
            if (first) begin
                hdr_r  <= in_header_i;
                addr_r <= in_addr_i;
                size_r <= in_size_i;
                wr_r   <= in_wr_i;
            end
        end
    end

    // ---------------- return path ----------------
    logic [cnt_w_lp-1:0]     rcnt;
    logic [cnt_w_lp-1:0]     r_last_idx;
    logic                    r_last;
    logic [data_width_p-1:0] rep_data;

    // Narrow reads: replicate the low 2^size bytes across the bus word.
    always_comb begin
        rep_data = '0;
        for (int unsigned i = 0; i < bus_bytes_lp; i++) begin
            if (32'(rsp_size_i) < lg_bus_bytes_lp)
                rep_data[i*8 +: 8] = rsp_data_i[(i & ((32'd1 << rsp_size_i) - 32'd1))*8 +: 8];
            else
                rep_data[i*8 +: 8] = rsp_data_i[i*8 +: 8];
        end
    end

    // Write responses collapse to one out beat; reads map 1:1.
    always_comb begin
        r_last_idx      = last_idx(rsp_size_i);
        r_last          = (rcnt == r_last_idx);
        out_header_o    = rsp_header_i;
        out_last_o      = r_last;
        out_v_o         = rsp_v_i;
        out_data_o      = rep_data;
        rsp_ready_and_o = out_ready_and_i;
        if (rsp_wr_i) begin
            out_v_o         = rsp_v_i & r_last;
            out_data_o      = '0;
            rsp_ready_and_o = r_last ? out_ready_and_i : 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                        rcnt <= '0;
        else if (rsp_v_i && rsp_ready_and_o) rcnt <= r_last ? '0 : rcnt + cnt_w_lp'(1);
    end

    // ---------------- simulation checks ----------------
    a_width_legal : assert property (@(posedge clk_i) legal_width_lp);

    a_addr_aligned : assert property (@(posedge clk_i) disable iff (reset_i)
        (in_v_i && first) |-> ((in_addr_i & paddr_width_p'(bus_bytes_lp - 1)) == '0));

    a_size_fits : assert property (@(posedge clk_i) disable iff (reset_i)
        (in_v_i && first) |-> (32'(in_size_i) <= lg_block_bytes_lp));

    a_wr_last_match : assert property (@(posedge clk_i) disable iff (reset_i)
        (fsm_yumi_i && fsm_wr_o) |-> (in_last_i == fsm_last_o));

    a_yumi_valid : assert property (@(posedge clk_i) disable iff (reset_i)
        fsm_yumi_i |-> fsm_v_o);

endmodule

// File: tb/tb_mem_stream_beat_pump.sv
// Scoreboard bench for mem_stream_beat_pump: stimulus pushes expected FSM
// beats and response-stream beats into queues; monitors pop and compare on
// every handshake.
module tb_mem_stream_beat_pump;

    localparam int unsigned PAW = 40;
    localparam int unsigned DW  = 64;
    localparam int unsigned BW  = 512;
    localparam int unsigned HW  = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [HW-1:0]   in_header;
    logic [PAW-1:0]  in_addr;
    logic [2:0]      in_size;
    logic            in_wr;
    logic [DW-1:0]   in_data;
    logic            in_v;
    logic            in_last;
    logic            in_ready;
    logic [HW-1:0]   fsm_header;
    logic [PAW-1:0]  fsm_addr;
    logic [2:0]      fsm_size;
    logic            fsm_wr;
    logic [DW-1:0]   fsm_data;
    logic            fsm_v;
    logic            fsm_new;
    logic            fsm_last;
    logic            fsm_yumi;
    logic [HW-1:0]   rsp_header;
    logic [2:0]      rsp_size;
    logic            rsp_wr;
    logic [DW-1:0]   rsp_data;
    logic            rsp_v;
    logic            rsp_ready;
    logic [HW-1:0]   out_header;
    logic [DW-1:0]   out_data;
    logic            out_v;
    logic            out_last;
    logic            out_ready;

    mem_stream_beat_pump #(
        .paddr_width_p(PAW), .data_width_p(DW), .block_width_p(BW), .header_width_p(HW)
    ) dut (
        .clk_i(clk), .reset_i(rst),
        .in_header_i(in_header), .in_addr_i(in_addr), .in_size_i(in_size), .in_wr_i(in_wr),
        .in_data_i(in_data), .in_v_i(in_v), .in_last_i(in_last), .in_ready_and_o(in_ready),
        .fsm_header_o(fsm_header), .fsm_addr_o(fsm_addr), .fsm_size_o(fsm_size), .fsm_wr_o(fsm_wr),
        .fsm_data_o(fsm_data), .fsm_v_o(fsm_v), .fsm_new_o(fsm_new), .fsm_last_o(fsm_last),
        .fsm_yumi_i(fsm_yumi),
        .rsp_header_i(rsp_header), .rsp_size_i(rsp_size), .rsp_wr_i(rsp_wr), .rsp_data_i(rsp_data),
        .rsp_v_i(rsp_v), .rsp_ready_and_o(rsp_ready),
        .out_header_o(out_header), .out_data_o(out_data), .out_v_o(out_v), .out_last_o(out_last),
        .out_ready_and_i(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PAW-1:0] addr;
        logic           nw;
        logic           last;
        logic [DW-1:0]  data;
        logic           rdy;
        logic [HW-1:0]  hdr;
        logic [2:0]     size;
        logic           wr;
    } fexp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [HW-1:0] hdr;
    } oexp_t;

    fexp_t fq[$];
    oexp_t oq[$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_f(input logic [PAW-1:0] addr, input logic nw, input logic last,
                          input logic [DW-1:0] data, input logic rdy, input logic [HW-1:0] hdr,
                          input logic [2:0] size, input logic wr);
        fexp_t e;
        e.addr = addr; e.nw = nw; e.last = last; e.data = data;
        e.rdy = rdy; e.hdr = hdr; e.size = size; e.wr = wr;
        fq.push_back(e);
    endtask

    task automatic push_o(input logic [DW-1:0] data, input logic last, input logic [HW-1:0] hdr);
        oexp_t e;
        e.data = data; e.last = last; e.hdr = hdr;
        oq.push_back(e);
    endtask

    // Forward monitor: one comparison set per FSM handshake.
    always @(negedge clk) begin : mon_fwd
        fexp_t e;
        if (!rst && fsm_v && fsm_yumi) begin
            if (fq.size() == 0) begin
                checks++; errors++;
                $display("FAIL fwd_unexpected: got beat at addr %h, expected none", fsm_addr);
            end else begin
                e = fq.pop_front();
                chk("fwd_addr",   64'(fsm_addr),   64'(e.addr));
                chk("fwd_new",    64'(fsm_new),    64'(e.nw));
                chk("fwd_last",   64'(fsm_last),   64'(e.last));
                chk("fwd_data",   fsm_data,        e.data);
                chk("fwd_ready",  64'(in_ready),   64'(e.rdy));
                chk("fwd_header", fsm_header,      e.hdr);
                chk("fwd_size",   64'(fsm_size),   64'(e.size));
                chk("fwd_wr",     64'(fsm_wr),     64'(e.wr));
            end
        end
    end

    // Response-stream monitor: one comparison set per out handshake.
    always @(negedge clk) begin : mon_out
        oexp_t e;
        if (!rst && out_v && out_ready) begin
            if (oq.size() == 0) begin
                checks++; errors++;
                $display("FAIL out_unexpected: got data %h last %0d, expected none", out_data, out_last);
            end else begin
                e = oq.pop_front();
                chk("out_data",   out_data,         e.data);
                chk("out_last",   64'(out_last),    64'(e.last));
                chk("out_header", out_header,       e.hdr);
            end
        end
    end

    // Read command: one held input beat, n FSM beats with yumi every cycle.
    task automatic fwd_read(input logic [2:0] size, input logic [PAW-1:0] addr,
                            input logic [HW-1:0] hdr, input int n);
        in_v = 1'b1; in_wr = 1'b0; in_last = 1'b1; in_size = size; in_addr = addr;
        in_header = hdr; in_data = 64'hBAD0_BAD0_BAD0_BAD0;
        fsm_yumi = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
        in_v = 1'b0; fsm_yumi = 1'b0; in_last = 1'b0;
    endtask

    // One response beat, held until accepted (bounded).
    task automatic rsp_beat(input logic [2:0] size, input logic wr, input logic [DW-1:0] data,
                            input logic [HW-1:0] hdr);
        logic acc;
        int   k;
        rsp_v = 1'b1; rsp_size = size; rsp_wr = wr; rsp_data = data; rsp_header = hdr;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 50) begin
            @(negedge clk);
            acc = rsp_ready;
            @(posedge clk); #1;
            k++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got no rsp_ready_and_o in 50 cycles, expected acceptance");
        end
        rsp_v = 1'b0;
    endtask

    logic [PAW-1:0] rd64_addr [8];
    logic           tog_done;

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd64_addr[0] = 40'h1018; rd64_addr[1] = 40'h1020; rd64_addr[2] = 40'h1028;
        rd64_addr[3] = 40'h1030; rd64_addr[4] = 40'h1038; rd64_addr[5] = 40'h1000;
        rd64_addr[6] = 40'h1008; rd64_addr[7] = 40'h1010;

        rst = 1'b1;
        in_header = '0; in_addr = '0; in_size = '0; in_wr = 1'b0; in_data = '0;
        in_v = 1'b0; in_last = 1'b0; fsm_yumi = 1'b0;
        rsp_header = '0; rsp_size = '0; rsp_wr = 1'b0; rsp_data = '0; rsp_v = 1'b0;
        out_ready = 1'b1;
        tog_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_new",   64'(fsm_new),   64'd1);
        chk("reset_out_v", 64'(out_v),     64'd0);
        chk("reset_fsm_v", 64'(fsm_v),     64'd0);

        // Single-beat read.
        push_f(40'h1000, 1'b1, 1'b1, '0, 1'b1, 64'hA0A0, 3'd3, 1'b0);
        fwd_read(3'd3, 40'h1000, 64'hA0A0, 1);

        // 64B wrapped read.
        for (int i = 0; i < 8; i++)
            push_f(rd64_addr[i], i == 0, i == 7, '0, i == 7, 64'hB0B0, 3'd6, 1'b0);
        fwd_read(3'd6, 40'h1018, 64'hB0B0, 8);

        // 32B write forward and write response concurrently.
        for (int i = 0; i < 4; i++)
            push_f(40'h2000 + 40'(i * 8), i == 0, i == 3, 64'(i + 1), 1'b1, 64'hC0C0, 3'd5, 1'b1);
        push_o('0, 1'b1, 64'hD0D0);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    in_v = 1'b1; in_data = 64'(i + 1); in_last = (i == 3);
                    if (i == 0) begin
                        in_wr = 1'b1; in_size = 3'd5; in_addr = 40'h2000; in_header = 64'hC0C0;
                    end else begin
                        // Command fields now garbage; DUT must use its held copy.
                        in_wr = 1'b0; in_size = 3'd0; in_addr = 40'h7770; in_header = 64'hEEEE;
                    end
                    fsm_yumi = 1'b1;
                    @(posedge clk); #1;
                end
                in_v = 1'b0; fsm_yumi = 1'b0; in_last = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++)
                    rsp_beat(3'd5, 1'b1, 64'hFACE_0000 + 64'(i), 64'hD0D0);
            end
        join

        // Narrow read replication and full-width passthrough.
        push_o(64'hABAB_ABAB_ABAB_ABAB, 1'b1, 64'hE1);
        rsp_beat(3'd0, 1'b0, 64'hFFEE_DDCC_BBAA_00AB, 64'hE1);
        push_o(64'h1234_5678_1234_5678, 1'b1, 64'hE2);
        rsp_beat(3'd2, 1'b0, 64'hDEAD_BEEF_1234_5678, 64'hE2);
        push_o(64'h0102_0304_0506_0708, 1'b1, 64'hE3);
        rsp_beat(3'd3, 1'b0, 64'h0102_0304_0506_0708, 64'hE3);

        // 64B read response with downstream ready toggling.
        for (int i = 0; i < 8; i++)
            push_o(64'h100 + 64'(i), i == 7, 64'hF0);
        fork
            begin
                for (int i = 0; i < 8; i++)
                    rsp_beat(3'd6, 1'b0, 64'h100 + 64'(i), 64'hF0);
                tog_done = 1'b1;
            end
            begin
                while (!tog_done) begin
                    @(posedge clk); #1;
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;

        // Reset after 3 of 8 beats; next read starts fresh.
        for (int i = 0; i < 3; i++)
            push_f(rd64_addr[i], i == 0, 1'b0, '0, 1'b0, 64'hB1B1, 3'd6, 1'b0);
        in_v = 1'b1; in_wr = 1'b0; in_last = 1'b1; in_size = 3'd6; in_addr = 40'h1018;
        in_header = 64'hB1B1; fsm_yumi = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mid_not_new", 64'(fsm_new), 64'd0);
        in_v = 1'b0; fsm_yumi = 1'b0; rst = 1'b1;
        #1;
        chk("midreset_new", 64'(fsm_new), 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        push_f(40'h3008, 1'b1, 1'b0, '0, 1'b0, 64'hB2B2, 3'd4, 1'b0);
        push_f(40'h3000, 1'b0, 1'b1, '0, 1'b1, 64'hB2B2, 3'd4, 1'b0);
        fwd_read(3'd4, 40'h3008, 64'hB2B2, 2);

        repeat (4) @(posedge clk);
        #1;
        chk("fwd_queue_drained", 64'(fq.size()), 64'd0);
        chk("out_queue_drained", 64'(oq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stream_beat_pump.md
Name: mem_stream_beat_pump

Overview:
- Bidirectional beat converter between multi-beat memory streams and a per-word FSM interface, sized for a bus-width memory master such as a Wishbone bridge.
- Forward side: turns a command stream into one FSM beat per bus word, with wrapped word addresses.
- Return side: turns FSM response beats back into a response stream, and replicates narrow read data across the bus word.

Parameters:
- paddr_width_p, 40: physical address width.
- data_width_p, 64: bus/beat width in bits; legal values 8, 16, 32, 64.
- block_width_p, 512: largest message in bits; must be a power-of-2 multiple of data_width_p.
- header_width_p, 64: opaque header payload width, passed through unchanged.
- Derived: bus_bytes = data_width_p/8; max_beats = block_width_p/data_width_p.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset.
- in_header_i  in  header_width_p  command header payload.
- in_addr_i  in  paddr_width_p  command address, bus-word aligned.
- in_size_i  in  3  log2 of message bytes.
- in_wr_i  in  1  1 = write (data on every beat), 0 = read (single header-only beat).
- in_data_i  in  data_width_p  write data beat.
- in_v_i / in_last_i  in  1  command beat valid / final beat.
- in_ready_and_o  out  1  command beat accepted when high with in_v_i.
- fsm_header_o  out  header_width_p  held header.
- fsm_addr_o  out  paddr_width_p  per-beat word address.
- fsm_size_o  out  3  held size.
- fsm_wr_o  out  1  held write flag.
- fsm_data_o  out  data_width_p  per-beat data.
- fsm_v_o / fsm_new_o / fsm_last_o  out  1  beat valid / first beat / final beat.
- fsm_yumi_i  in  1  consumer takes the beat.
- rsp_header_i  in  header_width_p  response header payload.
- rsp_size_i  in  3  response size.
- rsp_wr_i  in  1  response write flag.
- rsp_data_i  in  data_width_p  response data.
- rsp_v_i  in  1  response beat valid.
- rsp_ready_and_o  out  1  response beat accepted.
- out_header_o  out  header_width_p  response stream header.
- out_data_o  out  data_width_p  response stream data.
- out_v_o / out_last_o  out  1  response stream valid / final beat.
- out_ready_and_i  in  1  downstream ready.

Interface: one clock; reset is asynchronous and active-high (clk_i, reset_i).

Behaviour:
- beats = max(1, 2^size / bus_bytes), capped at max_beats. Sizes below bus width are one beat.
- Forward counter fcnt:
  - Reset: 0.
  - Increments on fsm_yumi_i; returns to 0 on the yumi of the last beat.
  - fsm_new_o = (fcnt==0).
  - fsm_last_o = (fcnt==beats-1).
- Header/addr/size/wr handling:
  - While fcnt==0: taken combinationally from the in_* ports.
  - On the first yumi of a multi-beat message: registered, and the held values are used for the remaining beats.
- Word address:
  - Word index = addr[log2(block_bytes)-1 : log2(bus_bytes)].
  - Low log2(beats) bits of the word index = (base + fcnt) mod beats (wrapped burst).
  - All other bits held; byte-offset bits are 0.
- Forward handshake:
  - fsm_v_o = in_v_i; fsm_yumi_i is asserted only when fsm_v_o is high.
  - Write: in_ready_and_o = fsm_yumi_i. One input beat per FSM beat; fsm_data_o = in_data_i. in_last_i is checked against fsm_last_o (simulation assertion).
  - Read: in_ready_and_o = fsm_yumi_i & fsm_last_o. The single input beat is held while beats FSM beats are generated; fsm_data_o = 0.
- Zero latency:
  - Forward path is combinational.
  - No combinational path from out_ready_and_i to in_ready_and_o.
- Return counter rcnt:
  - Reset: 0.
  - Increments per accepted rsp beat; wraps to 0 after beats-1, with beats computed from rsp_size_i.
- Read response:
  - Each rsp beat maps to one out beat: out_v_o = rsp_v_i, rsp_ready_and_o = out_ready_and_i.
  - out_last_o = (rcnt==beats-1).
- Write response:
  - Beats 0..beats-2 are accepted and dropped: rsp_ready_and_o = 1, out_v_o = 0.
  - The final beat is emitted as a single out beat with out_last_o = 1 and out_data_o = 0.
- Narrow read replication:
  - For rsp_size_i < log2(bus_bytes), out_data_o is the low 2^size bytes of rsp_data_i replicated to fill the bus.
  - Otherwise out_data_o = rsp_data_i unchanged.
- out_header_o = rsp_header_i.
- Reset mid-message: counters and held registers clear immediately. Any partial message is abandoned, and the next beat is treated as new.
- Simultaneous activity: forward and return paths are independent and may both handshake in the same cycle.
- Assertions (simulation only):
  - in_addr_i is bus-aligned.
  - Size does not exceed block.
  - data_width_p is legal.

Test Plan:
- Read, size 3 (8B), addr 0x1000 -> one FSM beat: addr 0x1000, new=1, last=1. in_ready_and_o follows yumi.
- Read, size 6 (64B), addr 0x1018 -> 8 FSM beats with addrs 0x1018, 0x1020 … 0x1038, 0x1000, 0x1008, 0x1010. last on the 8th beat only; in_ready_and_o pulses once.
- Write, size 5 (32B), addr 0x2000, data 1..4 -> 4 beats at 0x2000..0x2018, each paired 1:1 with input beats. The response side drops 3 beats and emits 1 out beat with last=1.
- Read response, size 0, rsp_data 0x…00AB -> out_data 0xABABABABABABABAB. Size 2, data 0x…12345678 -> 0x1234567812345678.
- 64B read response with out_ready_and_i toggling every cycle -> 8 beats, no loss or duplication, last on the 8th.
- reset_i asserted after FSM beat 3 of 8 -> fcnt=0. The next read produces new=1 at its own base address.
